sobel_window_ctrl: RTL

- Parametrised successor of the Sobel pixel-window controller.
- Scans a KERNEL x KERNEL window over an IMG_W x IMG_H image.
- Fills the window with a full row-major fetch. Within a row it slides by shifting and fetching one new column.
- Sequences the gradient calculation and result write through level req/done handshakes, and drives fetch coordinates and load indices to the datapath.

---
 rtl/sobel_pkg.sv | 21 ++
 rtl/sobel_scan_counter.sv | 44 ++++
 rtl/sobel_window_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared FSM state type and window-count helper for the Sobel window controller
package sobel_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILL_RD,
        S_FILL_LD,
        S_CALC,
        S_WRITE,
        S_ADVANCE,
        S_SHIFT,
        S_COL_RD,
        S_COL_LD,
        S_DONE
    } sobel_win_state_t;

    function automatic int win_count(input int k, input int w, input int h);
        return (h - k + 1) * (w - k + 1);
    endfunction

endpackage

// File: rtl/sobel_scan_counter.sv
// sobel_scan_counter: steps the window top-left corner across the image in raster order
//   clk, rst         clock, asynchronous active-high reset
//   clr              zero both coordinates (frame start / abort)
//   adv              one-cycle advance pulse; ignored on the last window
//   win_row/win_col  current window top-left corner
//   eol              window sits at the rightmost column
//   last             window is the final one of the frame
module sobel_scan_counter
    import sobel_pkg::*;
#(
    parameter int KERNEL  = 3,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               adv,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               eol,
    output logic               last
);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - KERNEL);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - KERNEL);

    assign eol  = win_col == LAST_COL;
    assign last = eol && win_row == LAST_ROW;

    // Coordinates freeze on the last window so they stay valid through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_row <= '0;
            win_col <= '0;
        end else if (clr) begin
            win_row <= '0;
            win_col <= '0;
        end else if (adv && !last) begin
            win_col <= eol ? '0 : win_col + 1'b1;
            win_row <= eol ? win_row + 1'b1 : win_row;
        end
    end
endmodule

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: scans a KERNEL x KERNEL window over the image, sequencing fetch, gradient and write
//   clk, rst                       clock, asynchronous active-high reset
//   start                          begin a frame (IDLE only)
//   rd_req/rd_row/rd_col/rd_valid  pixel fetch handshake and coordinates
//   load_en/load_idx               write fetched pixel into window slot r*KERNEL+c
//   shift_en                       shift window left one column
//   calc_req/calc_done             gradient handshake
//   wr_req/wr_done                 result write handshake
//   win_row/win_col                window top-left corner
//   busy, image_done               activity flag, end-of-frame pulse
//   abort                          only with SOBEL_WINDOW_CTRL_ABORT_EN: drop the frame, return to IDLE
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int KERNEL  = 3,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int COORD_W = 10,
    parameter int IDX_W   = 4
) (
`ifdef SOBEL_WINDOW_CTRL_ABORT_EN
    input  logic               abort,
`endif
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               rd_req,
    output logic [COORD_W-1:0] rd_row,
    output logic [COORD_W-1:0] rd_col,
    input  logic               rd_valid,
    output logic               load_en,
    output logic [IDX_W-1:0]   load_idx,
    output logic               shift_en,
    output logic               calc_req,
    input  logic               calc_done,
    output logic               wr_req,
    input  logic               wr_done,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               busy,
    output logic               image_done
);
    localparam logic [COORD_W-1:0] KM1 = COORD_W'(KERNEL - 1);

    if (KERNEL < 3 || KERNEL % 2 == 0 || IMG_W < KERNEL || IMG_H < KERNEL ||
        win_count(KERNEL, IMG_W, IMG_H) < 1 || (1 << COORD_W) < IMG_W ||
        (1 << COORD_W) < IMG_H || (1 << IDX_W) < KERNEL * KERNEL) begin : g_bad_params
        $error("sobel_window_ctrl: illegal parameter set");
    end

    sobel_win_state_t   state;
    logic [COORD_W-1:0] r;
    logic [COORD_W-1:0] c;
    logic               eol;
    logic               last;
    logic               abort_hit;

`ifdef SOBEL_WINDOW_CTRL_ABORT_EN
    assign abort_hit = abort && state != S_IDLE;
`else
    assign abort_hit = 1'b0;
`endif

    sobel_scan_counter #(
        .KERNEL (KERNEL),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .COORD_W(COORD_W)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .clr    ((state == S_IDLE && start) || abort_hit),
        .adv    (state == S_ADVANCE),
        .win_row(win_row),
        .win_col(win_col),
        .eol    (eol),
        .last   (last)
    );

    assign busy       = state != S_IDLE;
    assign rd_req     = state == S_FILL_RD || state == S_COL_RD;
    assign load_en    = state == S_FILL_LD || state == S_COL_LD;
    assign shift_en   = state == S_SHIFT;
    assign calc_req   = state == S_CALC;
    assign wr_req     = state == S_WRITE;
    assign image_done = state == S_DONE;
    assign rd_row     = win_row + r;
    assign rd_col     = win_col + c;
    assign load_idx   = IDX_W'(r * KERNEL + c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            r     <= '0;
            c     <= '0;
        end else if (abort_hit) begin
            state <= S_IDLE;
            r     <= '0;
            c     <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state <= S_FILL_RD;
                    r     <= '0;
                    c     <= '0;
                end
                S_FILL_RD: if (rd_valid) state <= S_FILL_LD;
                // Row-major walk: c wraps into r.
                S_FILL_LD: begin
                    c     <= (c == KM1) ? '0 : c + 1'b1;
                    r     <= (c != KM1) ? r : (r == KM1) ? '0 : r + 1'b1;
                    state <= (c == KM1 && r == KM1) ? S_CALC : S_FILL_RD;
                end
                S_CALC: if (calc_done) state <= S_WRITE;
                S_WRITE: if (wr_done) state <= S_ADVANCE;
                // A new row needs a full refill; within a row only one column is new.
                S_ADVANCE: begin
                    if (last) state <= S_DONE;
                    else if (eol) begin
                        state <= S_FILL_RD;
                        r     <= '0;
                        c     <= '0;
                    end else state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r     <= '0;
                    c     <= KM1;
                    state <= S_COL_RD;
                end
                S_COL_RD: if (rd_valid) state <= S_COL_LD;
                S_COL_LD: begin
                    r     <= (r == KM1) ? '0 : r + 1'b1;
                    state <= (r == KM1) ? S_CALC : S_COL_RD;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
